// File: rtl/hilo_mac_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : hilo_mac_unit_if
// Description : Issue/result bundle between the EX stage and the HI/LO
//               multiply-accumulate unit.
//                 start  issue strobe            op    3-bit operation code
//                 rs/rt  operands (rs = MTHI/MTLO source)
//                 flush  abort the op in flight
//                 busy   op in flight            done  multiply-class write pulse
//                 hi/lo  architectural HI/LO registers
// Revision    : 1.0 - initial release
// ============================================================================
interface hilo_mac_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] rs;
    logic [WIDTH-1:0] rt;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Pipeline side issues ops and observes the result.
    modport master (
        output start, op, rs, rt, flush,
        input  busy, done, hi, lo
    );

    // MAC unit side.
    modport slave (
        input  start, op, rs, rt, flush,
        output busy, done, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/hilo_mac_unit.sv
`default_nettype none
// ============================================================================
// Module      : hilo_mac_unit
// Description : Iterative radix-2 32x32 multiply-accumulate unit owning the
//               HI/LO pair. MULT(U)/MADD(U)/MSUB(U) form a 2*WIDTH product
//               over WIDTH cycles and then write, add or subtract it into
//               {HI,LO} in one extra cycle. MTHI/MTLO write directly.
// Ports       : clk    rising-edge clock
//               rst_n  asynchronous active-low reset
//               bus    hilo_mac_unit_if.slave (start/op/rs/rt/flush in,
//                      busy/done/hi/lo out)
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_mac_unit #(
    parameter int WIDTH = 32
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    hilo_mac_unit_if.slave   bus
);
    localparam int c_PW    = 2 * WIDTH;
    localparam int c_CNT_W = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ACC  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;

    logic [WIDTH-1:0]   r_mcand;     // multiplicand magnitude
    logic [WIDTH-1:0]   r_mplier;    // multiplier magnitude, shifted right each step
    logic [c_PW-1:0]    r_partial;
    logic [c_CNT_W-1:0] r_count;
    logic               r_neg;
    logic [1:0]         r_acc_sel;   // op[2:1]: 00 write, 01 add, 10 subtract
    logic [c_PW-1:0]    r_hilo;
    logic               r_done;

    logic               w_accept;
    logic               w_is_mt;
    logic               w_signed;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [c_PW-1:0]    w_addend;
    logic [c_PW-1:0]    w_prod;

    assign w_accept = (r_state == IDLE) && bus.start && !bus.flush;
    assign w_is_mt  = (bus.op[2:1] == 2'b11);
    assign w_signed = !bus.op[0];

    // Unary minus of the most negative value yields the same bit pattern,
    // which read as unsigned is exactly 2^(WIDTH-1), so no special case.
    assign w_mag_a = (w_signed && bus.rs[WIDTH-1]) ? -bus.rs : bus.rs;
    assign w_mag_b = (w_signed && bus.rt[WIDTH-1]) ? -bus.rt : bus.rt;

    assign w_addend = {{WIDTH{1'b0}}, r_mcand} << r_count;
    assign w_prod   = r_neg ? -r_partial : r_partial;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; flush always returns to IDLE without a write
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && !w_is_mt) begin
                    w_next = MUL;
                end
            end
            MUL: begin
                if (bus.flush) begin
                    w_next = IDLE;
                end else if (r_count == c_CNT_LAST) begin
                    w_next = ACC;
                end
            end
            ACC:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_partial <= '0;
            r_count   <= '0;
            r_neg     <= 1'b0;
            r_acc_sel <= 2'b00;
            r_hilo    <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_is_mt) begin
                            if (bus.op[0]) begin
                                r_hilo[WIDTH-1:0] <= bus.rs;
                            end else begin
                                r_hilo[c_PW-1:WIDTH] <= bus.rs;
                            end
                        end else begin
                            r_mcand   <= w_mag_a;
                            r_mplier  <= w_mag_b;
                            r_neg     <= w_signed && (bus.rs[WIDTH-1] ^ bus.rt[WIDTH-1]);
                            r_acc_sel <= bus.op[2:1];
                            r_partial <= '0;
                            r_count   <= '0;
                        end
                    end
                end
                MUL: begin
                    if (!bus.flush) begin
                        if (r_mplier[0]) begin
                            r_partial <= r_partial + w_addend;
                        end
                        r_mplier <= r_mplier >> 1;
                        r_count  <= r_count + c_CNT_ONE;
                    end
                end
                ACC: begin
                    if (!bus.flush) begin
                        case (r_acc_sel)
                            2'b01:   r_hilo <= r_hilo + w_prod;
                            2'b10:   r_hilo <= r_hilo - w_prod;
                            default: r_hilo <= w_prod;
                        endcase
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (r_state != IDLE);
    assign bus.done = r_done;
    assign bus.hi   = r_hilo[c_PW-1:WIDTH];
    assign bus.lo   = r_hilo[WIDTH-1:0];

endmodule
`default_nettype wire

// File: tb/tb_hilo_mac_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hilo_mac_unit
// Description : Self-checking bench for hilo_mac_unit. Directed cases plus a
//               randomized op stream compared against an arithmetic model of
//               the HI/LO pair, with cycle-exact busy/done timing checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hilo_mac_unit;
    localparam int WIDTH = 32;

    localparam logic [2:0] c_MULT  = 3'b000;
    localparam logic [2:0] c_MULTU = 3'b001;
    localparam logic [2:0] c_MADD  = 3'b010;
    localparam logic [2:0] c_MADDU = 3'b011;
    localparam logic [2:0] c_MSUB  = 3'b100;
    localparam logic [2:0] c_MTHI  = 3'b110;
    localparam logic [2:0] c_MTLO  = 3'b111;

    logic clk = 1'b0;
    logic rst_n;

    hilo_mac_unit_if #(.WIDTH(WIDTH)) bus ();

    hilo_mac_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] m_hilo;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_next(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b, input logic [63:0] acc);
        longint      sp;
        logic [63:0] p;
        if (o[0] == 1'b0) begin
            sp = longint'(signed'(a)) * longint'(signed'(b));
            p  = sp;
        end else begin
            p = {32'd0, a} * {32'd0, b};
        end
        case (o)
            c_MULT, c_MULTU:  return p;
            c_MADD, c_MADDU:  return acc + p;
            c_MTHI:           return {a, acc[31:0]};
            c_MTLO:           return {acc[63:32], a};
            default:          return acc - p;
        endcase
    endfunction

    // Called at a negedge; returns at a negedge one cycle later.
    task automatic mt(input logic [2:0] o, input logic [31:0] a);
        bus.start = 1'b1;
        bus.op    = o;
        bus.rs    = a;
        @(negedge clk);
        bus.start = 1'b0;
        m_hilo    = ref_next(o, a, 32'd0, m_hilo);
        check("mt_busy", {63'd0, bus.busy}, 64'd0);
        check("mt_done", {63'd0, bus.done}, 64'd0);
        check("mt_hilo", {bus.hi, bus.lo}, m_hilo);
    endtask

    // Called at a negedge; returns at the negedge of the done cycle (or the
    // first idle cycle after a flush) so the next op can issue back-to-back.
    // flush_cyc / poke_cyc: busy cycle (1-based) in which flush / a stray
    // start is driven; 0 means never.
    task automatic mul_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int flush_cyc, input int poke_cyc);
        int          n;
        logic [63:0] old;
        old       = m_hilo;
        bus.start = 1'b1;
        bus.op    = o;
        bus.rs    = a;
        bus.rt    = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.rs    = $urandom;
        bus.rt    = $urandom;
        n = 0;
        while (bus.busy === 1'b1 && n < 40) begin
            n++;
            check("mul_done_low", {63'd0, bus.done}, 64'd0);
            check("mul_hilo_hold", {bus.hi, bus.lo}, old);
            bus.start = (n == poke_cyc);
            bus.op    = (n == poke_cyc) ? c_MTLO : o;
            bus.flush = (n == flush_cyc);
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.flush = 1'b0;
        if (flush_cyc != 0) begin
            check("flush_len", 64'(n), 64'(flush_cyc));
            check("flush_done", {63'd0, bus.done}, 64'd0);
            check("flush_hilo", {bus.hi, bus.lo}, old);
        end else begin
            m_hilo = ref_next(o, a, b, old);
            check("busy_len", 64'(n), 64'd33);
            check("done_pulse", {63'd0, bus.done}, 64'd1);
            check("mul_result", {bus.hi, bus.lo}, m_hilo);
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [2:0]  ro;

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 3'b000;
        bus.rs    = '0;
        bus.rt    = '0;
        bus.flush = 1'b0;
        m_hilo    = 64'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_done", {63'd0, bus.done}, 64'd0);
        check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        mul_op(c_MULT, 32'hFFFF_FFFF, 32'h2, 0, 0);
        check("mult_neg", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFE);
        @(negedge clk);
        check("done_one_cycle", {63'd0, bus.done}, 64'd0);

        mul_op(c_MULTU, 32'hFFFF_FFFF, 32'h2, 0, 0);
        check("multu", {bus.hi, bus.lo}, 64'h0000_0001_FFFF_FFFE);
        mul_op(c_MULT, 32'h8000_0000, 32'h8000_0000, 0, 0);
        check("mult_minmin", {bus.hi, bus.lo}, 64'h4000_0000_0000_0000);

        mt(c_MTHI, 32'd0);
        mt(c_MTLO, 32'd5);
        mul_op(c_MADD, 32'd3, 32'd4, 0, 0);
        check("madd", {bus.hi, bus.lo}, 64'h0000_0000_0000_0011);

        mt(c_MTHI, 32'd0);
        mt(c_MTLO, 32'd0);
        mul_op(c_MSUB, 32'd1, 32'd1, 0, 0);
        check("msub", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFF);

        mt(c_MTHI, 32'hFFFF_FFFF);
        mt(c_MTLO, 32'hFFFF_FFFF);
        mul_op(c_MADDU, 32'd1, 32'd1, 0, 0);
        check("maddu_wrap", {bus.hi, bus.lo}, 64'd0);

        mt(c_MTHI, 32'h1234_5678);
        mt(c_MTLO, 32'h9ABC_DEF0);
        mul_op(c_MULT, 32'd7, 32'd9, 10, 0);
        check("flush_mid", {bus.hi, bus.lo}, 64'h1234_5678_9ABC_DEF0);
        mul_op(c_MULT, 32'd7, 32'd9, 33, 0);
        check("flush_acc", {bus.hi, bus.lo}, 64'h1234_5678_9ABC_DEF0);

        // Flush wins over start in IDLE.
        bus.start = 1'b1;
        bus.flush = 1'b1;
        bus.op    = c_MTHI;
        bus.rs    = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.start = 1'b0;
        bus.flush = 1'b0;
        check("flush_idle_busy", {63'd0, bus.busy}, 64'd0);
        check("flush_idle_hilo", {bus.hi, bus.lo}, m_hilo);

        // Asynchronous reset mid-operation.
        bus.start = 1'b1;
        bus.op    = c_MULT;
        bus.rs    = 32'd7;
        bus.rt    = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (19) @(negedge clk);
        check("pre_rst_busy", {63'd0, bus.busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        m_hilo = 64'd0;
        check("arst_busy", {63'd0, bus.busy}, 64'd0);
        check("arst_done", {63'd0, bus.done}, 64'd0);
        check("arst_hilo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Back-to-back: second op issues in the done cycle of the first.
        mul_op(c_MULT, 32'd2, 32'd3, 0, 0);
        mul_op(c_MADD, 32'd4, 32'd5, 0, 0);
        check("b2b", {bus.hi, bus.lo}, 64'h0000_0000_0000_001A);

        // Stray start while busy is ignored.
        mul_op(c_MULTU, $urandom, $urandom, 0, 5);

        for (int i = 0; i < 16; i++) begin
            ro = 3'($urandom_range(7));
            case ($urandom_range(3))
                0:       ra = 32'h8000_0000;
                1:       ra = 32'hFFFF_FFFF;
                default: ra = $urandom;
            endcase
            rb = ($urandom_range(3) == 0) ? 32'h8000_0000 : $urandom;
            if (ro[2:1] == 2'b11) begin
                mt(ro, ra);
            end else begin
                mul_op(ro, ra, rb, 0, 0);
            end
        end
        @(negedge clk);
        check("final_done_low", {63'd0, bus.done}, 64'd0);
        check("final_hilo", {bus.hi, bus.lo}, m_hilo);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/hilo_mac_unit.md
# hilo_mac_unit

Iterative 32x32 multiply-accumulate unit that owns the HI/LO register pair of the pipelined MIPS CPU. It executes MULT/MULTU/MADD/MADDU/MSUB/MSUBU/MTHI/MTLO. It forms a 64-bit product over 32 cycles and then adds it to, subtracts it from, or writes it over {HI,LO}. It sits beside the EX stage and asserts `busy` so hazard logic stalls any MFHI/MFLO or new MDU op.

## Interface
- `WIDTH`, 32, operand width. The product and {HI,LO} are 2*WIDTH. Only 32 is verified.
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  issue strobe. Sampled only when `busy`=0.
- `op`  in  3  operation code:
  - 000 MULT, 001 MULTU
  - 010 MADD, 011 MADDU
  - 100 MSUB, 101 MSUBU
  - 110 MTHI, 111 MTLO
- `rs`  in  WIDTH  operand A. Also the MTHI/MTLO source.
- `rt`  in  WIDTH  operand B
- `flush`  in  1  pipeline flush. Aborts the op in flight.
- `busy`  out  1  an op is in flight
- `done`  out  1  one-cycle pulse when HI/LO are written by a multiply-class op
- `hi`  out  WIDTH  HI register
- `lo`  out  WIDTH  LO register

## Operation
- FSM states are IDLE, MUL and ACC.
- IDLE, `start`=1, `flush`=0, op=MTHI/MTLO:
  - `hi`<=`rs` (MTHI) or `lo`<=`rs` (MTLO) on that edge.
  - Stay in IDLE. No `busy`, no `done`.
- IDLE, `start`=1, `flush`=0, multiply-class op:
  - Latch the op.
  - Signed ops (op[0]=0): latch |rs| and |rt|, and set neg = rs[31]^rt[31].
  - Unsigned ops: latch raw values and set neg=0.
  - Clear the 64-bit partial product and the 5-bit counter. Go to MUL.
- MUL: each cycle, radix-2 shift-add.
  - If the current multiplier LSB is 1, partial += multiplicand << counter.
  - Then counter++.
  - After counter 31 is processed, go to ACC.
- ACC, single cycle:
  - p = neg ? -partial : partial.
  - MULT/MULTU: {hi,lo} <= p.
  - MADD/MADDU: {hi,lo} <= {hi,lo}+p.
  - MSUB/MSUBU: {hi,lo} <= {hi,lo}-p.
  - Pulse `done`. Return to IDLE.
- Arithmetic is modulo 2^64. There is no overflow or trap indication.
- |−2^31| is 2^31, held as an unsigned 32-bit magnitude. The result must stay correct.
- `flush`=1 in MUL or ACC:
  - Next state is IDLE.
  - `hi`/`lo` are unchanged, no `done`, `busy` drops after that edge.
  - This also applies when `flush` coincides with the ACC cycle.
- `flush`=1 with `start`=1 in IDLE: flush wins, nothing is issued and nothing is written.
- `start` while `busy`=1 is ignored. Upstream must stall.
- Reset, at any time including mid-operation:
  - State is IDLE.
  - `hi`=`lo`=0, `busy`=0, `done`=0.
  - Counter, partial product and latched operands are cleared.

## Timing
- Edge E0 samples `start` in IDLE.
- `busy` is registered: 1 from after E0 until after E33, high for exactly 33 cycles.
- MUL iterations occur on edges E1–E32. ACC writes `hi`/`lo` on edge E33.
- `done`=1 for exactly the cycle after E33, with `busy`=0 in that cycle.
- New `hi`/`lo` are visible in the cycle after E33.
- Back-to-back: a new `start` is accepted in the cycle `done` is high, so the next E0 is E34.
- MTHI/MTLO take effect at E0 with 1-cycle write latency. `busy` is never raised.
- `hi`/`lo` hold their old values throughout MUL. MFHI during `busy` is the hazard unit's responsibility.

## Test plan
- Reset, then MULT rs=0xFFFFFFFF, rt=0x00000002 -> after 33 cycles hi=0xFFFFFFFF, lo=0xFFFFFFFE, `done` pulses once.
- MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE. MULT rs=0x80000000, rt=0x80000000 -> hi=0x40000000, lo=0x00000000.
- MTHI 0, then MTLO 5, then MADD 3×4 -> hi=0, lo=0x11.
- MTHI 0, then MTLO 0, then MSUB 1×1 -> hi=lo=0xFFFFFFFF.
- MTHI/MTLO to all-ones, then MADDU 1×1 -> hi=lo=0 (wrap).
- MULT 7×9 with `flush` asserted on cycle 10 of `busy` -> `busy` low next cycle, no `done`, hi/lo keep prior values.
- MULT 7×9 with `rst_n` pulsed low at cycle 20 -> immediate hi=lo=0, busy=0.
- Back-to-back MULT 2×3 then MADD 4×5 -> hi=0, lo=0x1A.
- `start` pulsed mid-op -> ignored.
